// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
package dmem_pkg;

    // Default storage depth in 32-bit words.
    localparam int MEM_WORDS_DEFAULT = 1024;

    // Legal range of the request-to-response latency, in clock cycles.
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    // Width of the latency down-counter; holds LATENCY_MAX - 1.
    localparam int CNT_W = 4;

    // Responder FSM: one outstanding request at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Force a requested latency into the supported range.
    function automatic int clamp_latency(input int lat);
        if (lat < LATENCY_MIN) return LATENCY_MIN;
        if (lat > LATENCY_MAX) return LATENCY_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator (master) and the responder (slave).
//
// Handshake rules, identical for both channels: the sender raises valid and
// holds valid plus its payload stable until the cycle in which ready is also
// high; the transfer happens on that rising clock edge. Valid never waits on
// ready. The request channel carries req_write/req_addr/req_wdata, the
// response channel carries resp_rdata/resp_err.
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_responder_mem_array.sv
// Word storage: synchronous write, registered read on enable, synchronous clear.
module mem_array #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    // Clear wipes every word and the read register; otherwise write and/or read one word.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder with a fixed, parameterised response latency.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int LATENCY   = 4
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_responder_if.slave bus,
    output state_e              dbg_state_o
);

    localparam int               AW         = $clog2(MEM_WORDS);
    localparam int               LAT        = clamp_latency(LATENCY);
    localparam logic [31:0]      ADDR_LIMIT = 32'(4 * MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             load_q, load_d;

    logic             accept;
    logic             addr_err;
    logic             mem_we;
    logic             mem_re;
    logic [AW-1:0]    word_idx;
    logic [31:0]      mem_rdata;

    // Request is taken only in IDLE; misaligned or out-of-range addresses never touch memory.
    assign accept   = bus.req_valid && bus.req_ready;
    assign addr_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= ADDR_LIMIT);
    assign word_idx = bus.req_addr[AW+1:2];
    assign mem_we   = accept && bus.req_write && !addr_err;
    assign mem_re   = accept && !bus.req_write && !addr_err;

    mem_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .clr_i   (!reset),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (word_idx),
        .wdata_i (bus.req_wdata),
        .rdata_o (mem_rdata)
    );

    // State, latency counter and response flags; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    // Next-state: accept -> count down LATENCY-1..0 -> present response until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load_d  = load_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    err_d   = addr_err;
                    load_d  = !bus.req_write && !addr_err;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load data only for good loads; stores and errors answer with zero data.
    assign bus.req_ready  = reset && (state_q == IDLE);
    assign bus.resp_valid = reset && (state_q == RESP);
    assign bus.resp_rdata = (reset && load_q) ? mem_rdata : 32'h0;
    assign bus.resp_err   = reset && err_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench: one LATENCY=4 responder and one LATENCY=1 responder.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int MW = 1024;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();
    state_e dbg_a;
    state_e dbg_b;

    data_mem_responder #(.MEM_WORDS(MW), .LATENCY(4)) dut_a (
        .clk         (clk),
        .reset       (rst_a),
        .bus         (bus_a),
        .dbg_state_o (dbg_a)
    );

    data_mem_responder #(.MEM_WORDS(MW), .LATENCY(1)) dut_b (
        .clk         (clk),
        .reset       (rst_b),
        .bus         (bus_b),
        .dbg_state_o (dbg_b)
    );

    int checks = 0;
    int errors = 0;

    // Expected responses as {resp_err, resp_rdata}.
    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    longint      acc_a = 0;
    longint      acc_b = 0;
    logic        prev_va = 1'b0;
    logic        prev_vb = 1'b0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one request on instance a (b=0) or b (b=1); returns just after the accept edge.
    task automatic send(input bit b, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [32:0] exp, input bit push);
        int n = 0;
        while (!(b ? bus_b.req_ready : bus_a.req_ready)) begin
            if (n == 100) begin
                checks++;
                errors++;
                $display("FAIL req_ready_timeout: inst %0d got no req_ready, required within 100 cycles", b);
                return;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (b) begin
            bus_b.req_valid = 1'b1; bus_b.req_write = wr; bus_b.req_addr = addr; bus_b.req_wdata = data;
        end else begin
            bus_a.req_valid = 1'b1; bus_a.req_write = wr; bus_a.req_addr = addr; bus_a.req_wdata = data;
        end
        @(posedge clk);
        if (b) acc_b = longint'($time); else acc_a = longint'($time);
        if (push) begin
            if (b) exp_b.push_back(exp); else exp_a.push_back(exp);
        end
        #1;
        if (b) bus_b.req_valid = 1'b0; else bus_a.req_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been consumed.
    task automatic drain();
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending a=%0d b=%0d, required 0", exp_a.size(), exp_b.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor a: latency of each rising resp_valid, and payload at each handshake.
    always @(negedge clk) begin
        if (bus_a.resp_valid && !prev_va) begin
            check("latency_a", 33'(longint'($time) - acc_a), 33'(4 * 10 + 5));
        end
        prev_va = bus_a.resp_valid;
        if (bus_a.resp_valid && bus_a.resp_ready) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp_a: got %h, required no response", {bus_a.resp_err, bus_a.resp_rdata});
            end else begin
                check("resp_a", {bus_a.resp_err, bus_a.resp_rdata}, exp_a.pop_front());
            end
        end
    end

    // Monitor b: same checks for the single-cycle-latency instance.
    always @(negedge clk) begin
        if (bus_b.resp_valid && !prev_vb) begin
            check("latency_b", 33'(longint'($time) - acc_b), 33'(1 * 10 + 5));
        end
        prev_vb = bus_b.resp_valid;
        if (bus_b.resp_valid && bus_b.resp_ready) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp_b: got %h, required no response", {bus_b.resp_err, bus_b.resp_rdata});
            end else begin
                check("resp_b", {bus_b.resp_err, bus_b.resp_rdata}, exp_b.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t1, t2, t3;
        int     n;

        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
        bus_a.resp_ready = 1'b1;
        bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
        bus_b.resp_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 33'(bus_a.req_ready), 33'(0));
        check("rst_resp_valid", 33'(bus_a.resp_valid), 33'(0));
        check("rst_resp", {bus_a.resp_err, bus_a.resp_rdata}, 33'(0));
        check("rst_state", 33'(dbg_a), 33'(IDLE));
        check("rst_req_ready_b", 33'(bus_b.req_ready), 33'(0));
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        check("release_req_ready", 33'(bus_a.req_ready), 33'(1));
        check("release_req_ready_b", 33'(bus_b.req_ready), 33'(1));
        @(posedge clk);
        #1;

        // Store/load, misaligned and out-of-range accesses, top word.
        send(0, 1, 32'h10,   32'hDEADBEEF, {1'b0, 32'h0},        1);
        send(0, 0, 32'h10,   32'h0,        {1'b0, 32'hDEADBEEF}, 1);
        send(0, 0, 32'h13,   32'h0,        {1'b1, 32'h0},        1);
        send(0, 0, 32'h10,   32'h0,        {1'b0, 32'hDEADBEEF}, 1);
        send(0, 0, 32'h1000, 32'h0,        {1'b1, 32'h0},        1);
        send(0, 1, 32'h1000, 32'h11111111, {1'b1, 32'h0},        1);
        send(0, 1, 32'h12,   32'h22222222, {1'b1, 32'h0},        1);
        send(0, 1, 32'hFFC,  32'hCAFEF00D, {1'b0, 32'h0},        1);
        send(0, 0, 32'hFFC,  32'h0,        {1'b0, 32'hCAFEF00D}, 1);
        send(0, 0, 32'h0,    32'h0,        {1'b0, 32'h0},        1);
        send(0, 0, 32'h10,   32'h0,        {1'b0, 32'hDEADBEEF}, 1);
        drain();

        // Back-pressure: response held 10 cycles while req_valid toggles.
        bus_a.resp_ready = 1'b0;
        send(0, 0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 1);
        n = 0;
        while (!bus_a.resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            bus_a.req_valid = i[0];
            bus_a.req_write = 1'b1;
            bus_a.req_addr  = 32'h10;
            bus_a.req_wdata = 32'h0;
            @(negedge clk);
            check("stall_valid", 33'(bus_a.resp_valid), 33'(1));
            check("stall_data", {bus_a.resp_err, bus_a.resp_rdata}, {1'b0, 32'hDEADBEEF});
            check("stall_req_ready", 33'(bus_a.req_ready), 33'(0));
            @(posedge clk);
            #1;
        end
        bus_a.req_valid  = 1'b0;
        bus_a.resp_ready = 1'b1;
        drain();
        send(0, 0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 1);
        drain();

        // Reset during WAIT aborts the transaction and clears memory.
        send(0, 1, 32'h20, 32'h5, 33'(0), 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_resp_valid", 33'(bus_a.resp_valid), 33'(0));
        check("abort_req_ready", 33'(bus_a.req_ready), 33'(0));
        check("abort_state", 33'(dbg_a), 33'(IDLE));
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(negedge clk);
        check("rerelease_req_ready", 33'(bus_a.req_ready), 33'(1));
        @(posedge clk);
        #1;
        send(0, 0, 32'h10,  32'h0, {1'b0, 32'h0}, 1);
        send(0, 0, 32'h20,  32'h0, {1'b0, 32'h0}, 1);
        send(0, 0, 32'hFFC, 32'h0, {1'b0, 32'h0}, 1);
        drain();

        // LATENCY=1: back-to-back requests, accept one cycle after each handshake.
        send(1, 1, 32'h4, 32'hA5A5A5A5, {1'b0, 32'h0}, 1);
        t1 = acc_b;
        send(1, 0, 32'h4, 32'h0, {1'b0, 32'hA5A5A5A5}, 1);
        t2 = acc_b;
        send(1, 0, 32'h8, 32'h0, {1'b0, 32'h0}, 1);
        t3 = acc_b;
        check("b2b_gap1", 33'(t2 - t1), 33'(30));
        check("b2b_gap2", 33'(t3 - t2), 33'(30));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 4: cycles from request accept to response valid; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low (0 = reset, sampled on rising clk).
REQ-005 SHALL have port req_valid, input, 1: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1: the responder can accept a request.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data.
REQ-010 SHALL have port resp_valid, output, 1: a response is presented.
REQ-011 SHALL have port resp_ready, input, 1: the initiator accepts the response.
REQ-012 SHALL have port resp_rdata, output, 32: load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1: the request was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE, so at most one request is outstanding.
REQ-016 SHALL accept a request on the edge where req_valid && req_ready, then move IDLE->WAIT and load the counter with LATENCY-1.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the edge where the counter equals 0, so resp_valid first rises exactly LATENCY cycles after the accept edge.
REQ-018 SHALL, in RESP, hold resp_valid, resp_rdata and resp_err stable until resp_valid && resp_ready, then return to IDLE on that edge.
REQ-019 SHALL NOT accept a new request in the handshake cycle; the next accept is possible one cycle later.
REQ-020 SHALL use word index req_addr[log2(MEM_WORDS)+1:2].
REQ-021 SHALL flag an error when req_addr[1:0]!=0 or when req_addr>=4*MEM_WORDS.
REQ-022 SHALL, on an error, leave memory unmodified, set resp_err=1 and resp_rdata=0.
REQ-023 SHALL commit a valid store to the array on the accept edge.
REQ-024 SHALL capture load data into the response register on the accept edge; a load after a store to the same address returns the stored value.
REQ-025 SHALL ignore req_* inputs outside IDLE; changes while busy have no effect.
REQ-026 SHALL, with resp_ready held 1, still present resp_valid for at least one cycle.

Reset
REQ-027 SHALL, while reset=0, force state IDLE, counter 0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, and clear all memory words to 0.
REQ-028 SHALL, when reset is asserted mid-operation (WAIT or RESP), abort the transaction with no response; a store already committed stays as zero, because memory is cleared.
REQ-029 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Structure
REQ-030 SHALL place the FSM state typedef, the LATENCY legal-range constants and the default MEM_WORDS in a shared package, dmem_pkg.
REQ-031 SHALL isolate the storage in one sub-module, mem_array: word array with synchronous write, synchronous read on enable, and synchronous clear.
REQ-032 SHALL keep the FSM, counter and error check in data_mem_responder.

Verification
REQ-033 SHALL cover: reset released, store addr 0x10 data 0xDEADBEEF, then load 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 4 cycles after each accept.
REQ-034 SHALL cover: load 0x13 (misaligned) -> resp_err=1, resp_rdata=0; a following load of 0x10 still returns the prior value.
REQ-035 SHALL cover: load 4*MEM_WORDS (0x1000) -> resp_err=1; store to 0xFFC -> a later load of 0xFFC returns the data.
REQ-036 SHALL cover: resp_ready held 0 for 10 cycles in RESP -> resp_valid and data stable and req_ready=0 throughout; req_valid toggled meanwhile -> no extra accept.
REQ-037 SHALL cover: reset=0 asserted during WAIT -> next cycle resp_valid=0, req_ready=0; after release, load of any address -> 0.
REQ-038 SHALL cover: LATENCY=1 instance with back-to-back requests and resp_ready=1 -> accept, response the next cycle, accept again one cycle after the handshake.
